fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Receiving end of the fetch interface. Buffers instruction/PC tuples produced by instruction_fetch and presents them in order to the decode stage through a valid/ready handshake. Decouples fetch from decode stalls and discards all buffered wrong-path instructions on a branch redirect. Sits between instruction_fetch and the decode stage (IF/ID boundary).

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
Branchreg  input  1  branch redirect; flushes the queue
instruction_in  input  32  instruction word from fetch
PC_in  input  64  PC of instruction_in
PC_branch_link_in  input  64  PC_in+4 from fetch (link value)
fetch_valid  input  1  fetch presents a valid tuple this cycle
fetch_ready  output  1  queue can accept a tuple; low stalls the PC
instruction_out  output  32  head instruction to decode
PC_out  output  64  head PC
PC_branch_link_out  output  64  head link value
decode_valid  output  1  head entry is valid
decode_ready  input  1  decode consumes the head this cycle
count  output  PTR_W+1  number of occupied entries, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous): read pointer, write pointer and count go to 0. decode_valid=0, fetch_ready=1, instruction_out=32'hD503201F (ARMv8 NOP), PC_out=0, PC_branch_link_out=0. Storage contents are don't-care.
- Storage: DEPTH entries of {instruction, PC, link} (160 bits). Pointers are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits.
- Push: fetch_valid && fetch_ready. Writes the tuple at the write pointer, then increments the write pointer.
- Pop: decode_valid && decode_ready. Increments the read pointer.
- fetch_ready = (count != DEPTH). It is registered-state-derived and does not depend on decode_ready. A full queue therefore does not accept a push in the same cycle as a pop; the pushed tuple is accepted one cycle later.
- decode_valid = (count != 0).
- Outputs (first-word fall-through):
  - When count != 0, instruction_out, PC_out and PC_branch_link_out show the head entry combinationally from storage.
  - When count == 0, they show NOP, 0, 0.
- Latency: no bypass. A tuple pushed into an empty queue appears on the outputs with decode_valid=1 on the next cycle.
- Count update, by case:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together (queue neither empty nor full): unchanged, and both pointers advance.
- Flush: Branchreg=1 at a clock edge resets both pointers and count to 0.
  - Flush has priority over push and pop. A push or pop in the same cycle is discarded and has no effect.
  - The next cycle shows decode_valid=0 and fetch_ready=1.
  - Branchreg held high for several cycles keeps the queue empty.
- Pop when empty and push when full cannot occur, because they are gated by decode_valid and fetch_ready. Neither pointer moves in those cases.
- Reset asserted mid-operation discards all entries immediately (asynchronous), with the outputs at their reset values.
- Entry order is strict FIFO. No entry is duplicated or reordered across pointer wrap-around.

Test Plan:
- Reset then idle: after release, count=0, decode_valid=0, fetch_ready=1, instruction_out=D503201F, PC_out=0.
- Single push: push {instr 8B020020, PC 0x1000, link 0x1004} with decode_ready=0. The next cycle shows decode_valid=1, instruction_out=8B020020, PC_out=0x1000, PC_branch_link_out=0x1004, count=1.
- Fill and stall:
  - Push PCs 0x0, 0x4, 0x8, 0xC with decode_ready=0. After the fourth push, count=4 and fetch_ready=0.
  - A fifth fetch_valid tuple is not accepted.
  - Raise decode_ready for one cycle: PC_out goes 0x0→0x4, count=3, fetch_ready=1.
- Streaming wrap-around: hold fetch_valid=1 and decode_ready=1 for 12 cycles with PCs incrementing by 4. Decode sees PCs in order 0x0..0x2C with no gaps or repeats. count stays at 1 after the first cycle. Pointers wrap three times.
- Flush with simultaneous push/pop:
  - With count=3 and fetch_valid=1, decode_ready=1, assert Branchreg for one cycle.
  - The next cycle shows count=0, decode_valid=0, outputs NOP/0/0.
  - The following push of PC 0x2000 becomes the head.
- Asynchronous reset mid-stream: drop reset between clock edges with count=2. decode_valid falls immediately, before the next edge, and count=0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The slave modport is the queue's view; the master modport is the driver side.
interface fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             Branchreg;
  logic [31:0]      instruction_in;
  logic [63:0]      PC_in;
  logic [63:0]      PC_branch_link_in;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [31:0]      instruction_out;
  logic [63:0]      PC_out;
  logic [63:0]      PC_branch_link_out;
  logic             decode_valid;
  logic             decode_ready;
  logic [PTR_W:0]   count;

  modport master (
    output Branchreg, instruction_in, PC_in, PC_branch_link_in, fetch_valid, decode_ready,
    input  fetch_ready, instruction_out, PC_out, PC_branch_link_out, decode_valid, count
  );

  modport slave (
    input  Branchreg, instruction_in, PC_in, PC_branch_link_in, fetch_valid, decode_ready,
    output fetch_ready, instruction_out, PC_out, PC_branch_link_out, decode_valid, count
  );
endinterface

// File: rtl/fetch_queue.sv
// IF/ID instruction queue: first-word fall-through FIFO of {instruction, PC, link}
// tuples, flushed on a branch redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] link;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [31:0]    NOP  = 32'hD503201F;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  entry_t           head;

  // Ready is purely state-derived so the fetch PC stall never waits on decode.
  assign bus.fetch_ready  = (count_q != FULL);
  assign bus.decode_valid = (count_q != '0);
  assign bus.count        = count_q;

  assign push = bus.fetch_valid && bus.fetch_ready;
  assign pop  = bus.decode_valid && bus.decode_ready;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.Branchreg) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: bus.instruction_in,
                            pc:    bus.PC_in,
                            link:  bus.PC_branch_link_in};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (bus.decode_valid) begin
      bus.instruction_out    = head.instr;
      bus.PC_out             = head.pc;
      bus.PC_branch_link_out = head.link;
    end else begin
      bus.instruction_out    = NOP;
      bus.PC_out             = '0;
      bus.PC_branch_link_out = '0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reference occupancy model plus a tuple
// scoreboard predict every output at each cycle.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct packed {
    logic [31:0] i;
    logic [63:0] pc;
    logic [63:0] link;
  } tup_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_queue_if #(.PTR_W(PTR_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  tup_t sb[$];
  int   mcount;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 64'(bus.count), 64'(mcount));
    check({tag, ".decode_valid"}, 64'(bus.decode_valid), 64'(mcount != 0));
    check({tag, ".fetch_ready"}, 64'(bus.fetch_ready), 64'(mcount != DEPTH));
    if (mcount != 0) begin
      check({tag, ".instr"}, 64'(bus.instruction_out), 64'(sb[0].i));
      check({tag, ".pc"}, bus.PC_out, sb[0].pc);
      check({tag, ".link"}, bus.PC_branch_link_out, sb[0].link);
    end else begin
      check({tag, ".instr"}, 64'(bus.instruction_out), 64'(NOP));
      check({tag, ".pc"}, bus.PC_out, 64'h0);
      check({tag, ".link"}, bus.PC_branch_link_out, 64'h0);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    logic [15:0] lo;
    lo = pc[15:0];
    return {16'hA5C3, lo ^ 16'h1357};
  endfunction

  // One clock cycle: drive, check pre-edge outputs, advance the model after the edge.
  task automatic cyc(input string tag, input logic fv, input logic [31:0] instr,
                     input logic [63:0] pc, input logic dr, input logic br);
    tup_t t;
    logic push, pop;
    t.i  = instr;
    t.pc = pc;
    t.link = pc + 64'd4;
    bus.fetch_valid       = fv;
    bus.instruction_in    = instr;
    bus.PC_in             = pc;
    bus.PC_branch_link_in = pc + 64'd4;
    bus.decode_ready      = dr;
    bus.Branchreg         = br;
    #1;
    check_state(tag);
    push = fv && (mcount != DEPTH);
    pop  = dr && (mcount != 0);
    @(posedge clock);
    #1;
    if (br) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(t);
      mcount = mcount + (push ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mcount  = 0;
    bus.fetch_valid       = 1'b0;
    bus.instruction_in    = '0;
    bus.PC_in             = '0;
    bus.PC_branch_link_in = '0;
    bus.decode_ready      = 1'b0;
    bus.Branchreg         = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clock);
    #1;
    check_state("in_reset");
    reset = 1'b1;
    cyc("idle0", 1'b0, '0, 64'h0, 1'b0, 1'b0);
    cyc("idle1", 1'b0, '0, 64'h0, 1'b0, 1'b0);

    // Single push, visible one cycle later, then consumed
    cyc("single_push", 1'b1, 32'h8B020020, 64'h1000, 1'b0, 1'b0);
    check("single.pc_literal", bus.PC_out, 64'h1000);
    check("single.instr_literal", 64'(bus.instruction_out), 64'h8B020020);
    cyc("single_hold", 1'b0, '0, 64'h0, 1'b1, 1'b0);
    cyc("single_empty", 1'b0, '0, 64'h0, 1'b0, 1'b0);

    // Fill to DEPTH, fifth push refused, one pop frees a slot
    for (int i = 0; i < DEPTH; i++)
      cyc("fill", 1'b1, mk_instr(64'(i * 4)), 64'(i * 4), 1'b0, 1'b0);
    check("fill.fetch_ready_low", 64'(bus.fetch_ready), 64'h0);
    cyc("fifth_refused", 1'b1, mk_instr(64'h10), 64'h10, 1'b0, 1'b0);
    cyc("full_pop", 1'b0, '0, 64'h0, 1'b1, 1'b0);
    check("full_pop.pc_after", bus.PC_out, 64'h4);
    for (int i = 0; i < 3; i++)
      cyc("drain", 1'b0, '0, 64'h0, 1'b1, 1'b0);

    // Streaming across pointer wrap
    for (int i = 0; i < 12; i++)
      cyc("stream", 1'b1, mk_instr(64'(i * 4)), 64'(i * 4), 1'b1, 1'b0);
    check("stream.count_one", 64'(bus.count), 64'h1);
    check("stream.last_pc", bus.PC_out, 64'h2C);
    cyc("stream_drain", 1'b0, '0, 64'h0, 1'b1, 1'b0);

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++)
      cyc("pre_flush", 1'b1, mk_instr(64'(32'h100 + i * 4)), 64'(32'h100 + i * 4), 1'b0, 1'b0);
    cyc("flush", 1'b1, mk_instr(64'h200), 64'h200, 1'b1, 1'b1);
    check("flush.count_zero", 64'(bus.count), 64'h0);
    cyc("after_flush_push", 1'b1, mk_instr(64'h2000), 64'h2000, 1'b0, 1'b0);
    cyc("after_flush_head", 1'b0, '0, 64'h0, 1'b0, 1'b0);
    check("flush.new_head", bus.PC_out, 64'h2000);

    // Branchreg held high keeps the queue empty
    cyc("hold_flush0", 1'b1, mk_instr(64'h3000), 64'h3000, 1'b0, 1'b1);
    cyc("hold_flush1", 1'b1, mk_instr(64'h3004), 64'h3004, 1'b0, 1'b1);
    cyc("hold_flush2", 1'b0, '0, 64'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with two entries
    cyc("pre_rst0", 1'b1, mk_instr(64'h4000), 64'h4000, 1'b0, 1'b0);
    cyc("pre_rst1", 1'b1, mk_instr(64'h4004), 64'h4004, 1'b0, 1'b0);
    bus.fetch_valid = 1'b0;
    #1;
    check("pre_rst.count_two", 64'(bus.count), 64'h2);
    #1;
    reset = 1'b0;
    #1;
    sb.delete();
    mcount = 0;
    check_state("async_rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc("post_rst_push", 1'b1, mk_instr(64'h5000), 64'h5000, 1'b0, 1'b0);
    cyc("post_rst_pop", 1'b0, '0, 64'h0, 1'b1, 1'b0);
    cyc("post_rst_idle", 1'b0, '0, 64'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
